cp0_regs: RTL
=============

Name: cp0_regs

Overview:
Coprocessor-0 register file that consumes the exception record (Exc, BadVAddr, Cause, EPC) produced by the memory stage. It sits alongside the writeback stage and commits that record into the architectural CP0 registers. It also services MTC0/MFC0/ERET and runs the Count/Compare timer. It produces the pipeline flush/redirect and the pending-interrupt request that feeds back into exception detection.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, redirect target on exception
STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
exc_in  in  1  exception commit from memory stage (one cycle per exception)
badvaddr_in  in  32  faulting address
cause_in  in  32  bit31=BD, bits6:2=ExcCode; other bits ignored
epc_in  in  32  already BD-corrected EPC
eret  in  1  ERET commits this cycle
mtc0_we  in  1  MTC0 commits this cycle
mtc0_addr  in  5  CP0 register number (sel=0)
mtc0_data  in  32  write data
mfc0_addr  in  5  read register number
ext_int  in  6  hardware interrupt lines, level-sensitive
mfc0_data  out  32  read data
flush  out  1  flush all younger stages
redirect_pc  out  32  next-PC when flush=1
epc  out  32  current EPC register
int_req  out  1  interrupt pending and enabled

Behaviour:
- Registers and reset values (all zero except Status=STATUS_RST): BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), tick flop=0, TI=0.
- Reset is asynchronous: it clears all state immediately, including mid-exception and mid-count.
- Commit priority in one cycle: exc_in > eret > mtc0_we. A lower-priority event in the same cycle is dropped entirely.
- On exc_in:
  - Status.EXL<=1.
  - Cause.ExcCode<=cause_in[6:2].
  - If Status.EXL was 0: EPC<=epc_in and Cause.BD<=cause_in[31]. If EXL was already 1: EPC and BD are held.
  - BadVAddr<=badvaddr_in only when ExcCode is 4 (AdEL) or 5 (AdES).
- On eret: Status.EXL<=0.
- MTC0 writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. Other bits are read-only; BEV stays at its reset value.
  - Cause: IP[1:0] (bits 9:8) only.
  - EPC, Count, Compare: full 32 bits.
  - Writing Compare clears TI.
  - BadVAddr and any other address: write ignored.
- MFC0 read is combinational from current register state, with no write bypass. Unimplemented addresses read 0.
- Cause composition:
  - Cause[31]=BD, Cause[30]=TI.
  - IP[7]=ext_int[5]|TI; IP[6:2]=ext_int[4:0], sampled into Cause every cycle.
  - IP[1:0] are software bits. Other bits are 0.
- Timer:
  - tick toggles every cycle; Count+=1 (wrapping 32'hFFFF_FFFF->0) on cycles where tick=1, i.e. every 2nd clk.
  - An MTC0 to Count that cycle overrides the increment.
  - TI<=1 when Count==Compare after the update. A Compare write in the same cycle wins (TI=0).
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). Combinational from registered state.
- flush = exc_in | eret. Combinational, same cycle.
- redirect_pc = exc_in ? EXC_VECTOR : EPC (the value before any same-cycle update).

Decomposition:
- Shared package cp0_pkg: register numbers (8,9,11,12,13,14), ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), EXC_VECTOR, Status/Cause bit-position constants.
- One sub-module, cp0_timer: tick, Count, Compare, TI, plus write and clear ports.

Test Plan:
1. Reset then read. Assert rst; deassert; mfc0 12 -> 32'h0040_0000; mfc0 13/14/8 -> 0; int_req=0.
2. AdEL commit. exc_in=1, cause_in ExcCode=4, BD=1, epc_in=32'h8000_0100, badvaddr_in=32'h8000_0203 -> flush=1, redirect_pc=32'hBFC0_0380. Next cycle: EPC=32'h8000_0100, BadVAddr=32'h8000_0203, Cause=32'h8000_0010, Status.EXL=1.
3. Nested exception while EXL=1. ExcCode=8, epc_in=32'h8000_0200 -> EPC unchanged, ExcCode=8, BadVAddr unchanged. Then eret -> flush=1, redirect_pc=old EPC, EXL=0 next cycle.
4. Timer. MTC0 Compare=5, Count=0 -> TI=1 once Count reaches 5 (about 10 clks). With Status=32'h0000_8001: int_req=1. MTC0 Compare=100 -> TI=0, int_req=0.
5. Simultaneous events. exc_in+eret+mtc0_we (EPC=0x1234) in one cycle -> exception applied, EXL=1, EPC=epc_in, MTC0 dropped. MTC0 Count=7 on a tick cycle -> Count=7.
6. Software interrupt / write masks. MTC0 Cause=32'hFFFF_FFFF -> only bits 9:8 set. Status=32'h0000_0101 -> int_req=1. Mid-stream async rst -> all registers return to reset values immediately.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and Status/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR     = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_VAL = 32'h0040_0000;

    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_EXL    = 1;
    localparam int unsigned CA_IP_SW0 = 8;
    localparam int unsigned CA_IP_SW1 = 9;

    // IM[15:8], EXL and IE are the only software-writable Status bits.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI latches on a compare match.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    logic [31:0] w_count_d;
    logic [31:0] w_compare_d;
    logic        w_count_upd;
    logic        w_ti_d;

    always_comb begin
        w_count_d   = r_count;
        w_count_upd = 1'b0;
        if (i_count_we) begin
            w_count_d   = i_wdata;
            w_count_upd = 1'b1;
        end else if (r_tick) begin
            w_count_d   = r_count + 32'd1;
            w_count_upd = 1'b1;
        end
        w_compare_d = i_compare_we ? i_wdata : r_compare;
        // Match is evaluated only when Count actually changes; a Compare write always clears TI.
        if (i_compare_we) begin
            w_ti_d = 1'b0;
        end else begin
            w_ti_d = r_ti | (w_count_upd & (w_count_d == w_compare_d));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            r_tick    <= ~r_tick;
            r_count   <= w_count_d;
            r_compare <= w_compare_d;
            r_ti      <= w_ti_d;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: commits exception records, services MTC0/MFC0/ERET, raises flush and
// interrupt requests.
module cp0_regs #(
    parameter logic [31:0] EXC_VECTOR = cp0_pkg::EXC_VECTOR,
    parameter logic [31:0] STATUS_RST = cp0_pkg::STATUS_RST_VAL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_in,
    input  logic [31:0] badvaddr_in,
    input  logic [31:0] cause_in,
    input  logic [31:0] epc_in,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_addr,
    input  logic [5:0]  ext_int,
    output logic [31:0] mfc0_data,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic        int_req
);
    import cp0_pkg::*;

    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_cause_bd;
    logic [4:0]  r_cause_exc;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_ext_int;

    logic        w_do_eret;
    logic        w_do_mtc0;
    logic [4:0]  w_exc_code;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [7:0]  w_ip;
    logic [31:0] w_cause;
    logic        w_unused;

    assign w_do_eret  = eret & ~exc_in;
    assign w_do_mtc0  = mtc0_we & ~exc_in & ~eret;
    assign w_exc_code = cause_in[6:2];
    assign w_unused   = ^{cause_in[30:7], cause_in[1:0]};

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_we   (w_do_mtc0 && (mtc0_addr == REG_COUNT)),
        .i_compare_we (w_do_mtc0 && (mtc0_addr == REG_COMPARE)),
        .i_wdata      (mtc0_data),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status    <= STATUS_RST;
            r_epc       <= 32'd0;
            r_badvaddr  <= 32'd0;
            r_cause_bd  <= 1'b0;
            r_cause_exc <= 5'd0;
            r_ip_sw     <= 2'd0;
            r_ext_int   <= 6'd0;
        end else begin
            r_ext_int <= ext_int;
            if (exc_in) begin
                r_status[ST_EXL] <= 1'b1;
                r_cause_exc      <= w_exc_code;
                // A nested exception keeps the EPC/BD of the outermost one.
                if (!r_status[ST_EXL]) begin
                    r_epc      <= epc_in;
                    r_cause_bd <= cause_in[31];
                end
                if (is_addr_exc(w_exc_code)) begin
                    r_badvaddr <= badvaddr_in;
                end
            end else if (w_do_eret) begin
                r_status[ST_EXL] <= 1'b0;
            end else if (w_do_mtc0) begin
                case (mtc0_addr)
                    REG_STATUS: r_status <= (r_status & ~STATUS_WMASK) | (mtc0_data & STATUS_WMASK);
                    REG_CAUSE:  r_ip_sw  <= mtc0_data[CA_IP_SW1:CA_IP_SW0];
                    REG_EPC:    r_epc    <= mtc0_data;
                    default:    ;
                endcase
            end
        end
    end

    assign w_ip    = {r_ext_int[5] | w_ti, r_ext_int[4:0], r_ip_sw};
    assign w_cause = {r_cause_bd, w_ti, 14'd0, w_ip, 1'b0, r_cause_exc, 2'd0};

    always_comb begin
        mfc0_data = 32'd0;
        case (mfc0_addr)
            REG_BADVADDR: mfc0_data = r_badvaddr;
            REG_COUNT:    mfc0_data = w_count;
            REG_COMPARE:  mfc0_data = w_compare;
            REG_STATUS:   mfc0_data = r_status;
            REG_CAUSE:    mfc0_data = w_cause;
            REG_EPC:      mfc0_data = r_epc;
            default:      mfc0_data = 32'd0;
        endcase
    end

    assign flush       = exc_in | eret;
    assign redirect_pc = exc_in ? EXC_VECTOR : r_epc;
    assign epc         = r_epc;
    assign int_req     = r_status[ST_IE] & ~r_status[ST_EXL] & (|(w_ip & r_status[15:8]));

endmodule
